// File: rtl/uart_rx_controller.sv
// uart_rx_controller
//
// Sequencing controller between a UART receiver and a byte-stream consumer.
// Accepts completed bytes from the receiver through its Ready/Enable
// handshake and buffers them in a first-word fall-through FIFO. A receiver
// error is recovered by pulsing the receiver reset low for RECOVER_CYCLES
// cycles, and each error is counted in a saturating counter.
//
// Ports
//   Clk         system clock, rising edge
//   Reset       asynchronous active-low reset
//   Enable      1 = receive, 0 = receiver held in reset, no accepts
//   RxData      byte from receiver, valid while RxReady=1
//   RxReady     receiver holds a complete byte
//   RxError     receiver error, sticky until receiver reset
//   RxEnable    registered one-cycle pulse consuming the held byte
//   RxResetN    registered active-low receiver reset
//   OutData     FIFO head byte (last popped byte while empty)
//   OutValid    FIFO not empty
//   OutReady    consumer pops head when OutValid=1
//   FifoLevel   bytes stored, 0..DEPTH
//   ErrorCount  saturating receiver-error count
//   ErrorClear  synchronous clear of ErrorCount
//
// state         | meaning
// --------------+----------------------------------------------------------
// StateDisabled | receiver held in reset, nothing accepted
// StateWait     | waiting for a byte or an error from the receiver
// StateRelease  | byte captured, RxEnable pulse consumes it in the receiver
// StateRecover  | receiver reset held low while the recovery timer runs

module uart_rx_controller #(
    parameter int DEPTH          = 8,
    parameter int ADDR_WIDTH     = 3,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic [7:0]            RxData,
    input  logic                  RxReady,
    input  logic                  RxError,
    output logic                  RxEnable,
    output logic                  RxResetN,
    output logic [7:0]            OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [ADDR_WIDTH:0]   FifoLevel,
    output logic [7:0]            ErrorCount,
    input  logic                  ErrorClear
);

    localparam int CntWidth = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [ADDR_WIDTH:0] LevelFull = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LevelOne  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        StateDisabled,
        StateWait,
        StateRelease,
        StateRecover
    } StateT;

    StateT                 state;
    StateT                 nextState;
    logic [CntWidth-1:0]   recoverCnt;
    logic [CntWidth-1:0]   nextRecoverCnt;

    logic [7:0]            fifoMem [DEPTH];
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [7:0]            lastPopped;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  fifoWrite;
    logic                  fifoPop;
    logic                  errorEvent;

    assign fifoFull  = (FifoLevel == LevelFull);
    assign fifoEmpty = (FifoLevel == '0);
    assign OutValid  = !fifoEmpty;
    assign fifoPop   = OutValid & OutReady;
    // While empty the head slot holds stale data, so show the last popped byte.
    assign OutData   = fifoEmpty ? lastPopped : fifoMem[rdPtr];

    always_comb begin
        nextState      = state;
        nextRecoverCnt = recoverCnt;
        fifoWrite      = 1'b0;
        errorEvent     = 1'b0;
        if (!Enable) begin
            nextState = StateDisabled;
        end else begin
            case (state)
                StateDisabled: nextState = StateWait;
                StateWait: begin
                    if (RxError) begin
                        nextState      = StateRecover;
                        nextRecoverCnt = CntWidth'(RECOVER_CYCLES - 1);
                        errorEvent     = 1'b1;
                    end else if (RxReady && !fifoFull) begin
                        fifoWrite = 1'b1;
                        nextState = StateRelease;
                    end
                end
                // RxReady stays high until the receiver sees RxEnable; ignore it here.
                StateRelease: nextState = StateWait;
                StateRecover: begin
                    if (recoverCnt == '0) begin
                        nextState = StateWait;
                    end else begin
                        nextRecoverCnt = recoverCnt - CntWidth'(1);
                    end
                end
                default: nextState = StateDisabled;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= StateDisabled;
            recoverCnt <= '0;
            RxEnable   <= 1'b0;
            RxResetN   <= 1'b0;
        end else begin
            state      <= nextState;
            recoverCnt <= nextRecoverCnt;
            RxEnable   <= (nextState == StateRelease);
            RxResetN   <= !((nextState == StateDisabled) || (nextState == StateRecover));
        end
    end

    always_ff @(posedge Clk) begin
        if (fifoWrite) begin
            fifoMem[wrPtr] <= RxData;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            FifoLevel  <= '0;
            lastPopped <= '0;
        end else begin
            if (fifoWrite) begin
                wrPtr <= wrPtr + PtrOne;
            end
            if (fifoPop) begin
                rdPtr      <= rdPtr + PtrOne;
                lastPopped <= fifoMem[rdPtr];
            end
            case ({fifoWrite, fifoPop})
                2'b10:   FifoLevel <= FifoLevel + LevelOne;
                2'b01:   FifoLevel <= FifoLevel - LevelOne;
                default: FifoLevel <= FifoLevel;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ErrorCount <= '0;
        end else if (ErrorClear) begin
            ErrorCount <= errorEvent ? 8'd1 : 8'd0;
        end else if (errorEvent && (ErrorCount != 8'hFF)) begin
            ErrorCount <= ErrorCount + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
module tb_uart_rx_controller;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int RC    = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [7:0]  RxData;
    logic        RxReady;
    logic        RxError;
    logic        RxEnable;
    logic        RxResetN;
    logic [7:0]  OutData;
    logic        OutValid;
    logic        OutReady;
    logic [AW:0] FifoLevel;
    logic [7:0]  ErrorCount;
    logic        ErrorClear;

    int checks = 0;
    int errors = 0;

    uart_rx_controller #(
        .DEPTH(DEPTH),
        .ADDR_WIDTH(AW),
        .RECOVER_CYCLES(RC)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Enable(Enable),
        .RxData(RxData),
        .RxReady(RxReady),
        .RxError(RxError),
        .RxEnable(RxEnable),
        .RxResetN(RxResetN),
        .OutData(OutData),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .FifoLevel(FifoLevel),
        .ErrorCount(ErrorCount),
        .ErrorClear(ErrorClear)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       en;
        logic       rdy;
        logic [7:0] data;
        logic       err;
        logic       ordy;
        logic       clr;
        logic       expRxEn;
        logic       expRstN;
        logic       expValid;
        logic [7:0] expData;
        int         expLevel;
        int         expErr;
    } VecT;

    VecT vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, output bit ok);
        RxData  = b;
        RxReady = 1'b1;
        ok      = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (RxEnable === 1'b1) ok = 1'b1;
        end
        tick();
        RxReady = 1'b0;
    endtask

    initial begin
        bit         ok;
        bit         seen;
        bit [7:0]   q[$];
        bit [7:0]   lastPop;
        bit         prevAccept;
        bit         accept;
        int         stage;

        Reset = 1'b0; Enable = 1'b0; RxData = 8'h00; RxReady = 1'b0;
        RxError = 1'b0; OutReady = 1'b0; ErrorClear = 1'b0;
        repeat (2) tick();
        check("reset RxEnable",   32'(RxEnable),   32'd0);
        check("reset RxResetN",   32'(RxResetN),   32'd0);
        check("reset OutValid",   32'(OutValid),   32'd0);
        check("reset OutData",    32'(OutData),    32'd0);
        check("reset FifoLevel",  32'(FifoLevel),  32'd0);
        check("reset ErrorCount", 32'(ErrorCount), 32'd0);
        Reset = 1'b1;

        // en rdy data err ordy clr | RxEn RstN Valid Data Level Err
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1, 0};
        vecs[2]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1, 0};
        vecs[3]  = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 2, 0};
        vecs[4]  = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 2, 0};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 1, 0};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 1, 1};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 1, 1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 1, 1};
        vecs[9]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 2, 1};
        vecs[10] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 2, 1};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1, 1};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 0, 1};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 0, 1};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 1};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 0};
        vecs[16] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 0};
        vecs[17] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 0, 0};
        vecs[18] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1, 0};
        vecs[19] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1, 0};
        vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 0, 0};

        for (int i = 0; i < 21; i++) begin
            Enable = vecs[i].en; RxReady = vecs[i].rdy; RxData = vecs[i].data;
            RxError = vecs[i].err; OutReady = vecs[i].ordy; ErrorClear = vecs[i].clr;
            tick();
            check($sformatf("v%0d RxEnable", i),   32'(RxEnable),   32'(vecs[i].expRxEn));
            check($sformatf("v%0d RxResetN", i),   32'(RxResetN),   32'(vecs[i].expRstN));
            check($sformatf("v%0d OutValid", i),   32'(OutValid),   32'(vecs[i].expValid));
            check($sformatf("v%0d OutData", i),    32'(OutData),    32'(vecs[i].expData));
            check($sformatf("v%0d FifoLevel", i),  32'(FifoLevel),  vecs[i].expLevel);
            check($sformatf("v%0d ErrorCount", i), 32'(ErrorCount), vecs[i].expErr);
        end
        RxReady = 1'b0; OutReady = 1'b0; ErrorClear = 1'b0; RxError = 1'b0;

        // Backpressure: fill to DEPTH, ninth byte must wait in the receiver.
        Enable = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            sendByte(8'(8'h10 + i), ok);
            check($sformatf("bp accept %0d", i), 32'(ok), 32'd1);
        end
        check("bp level full", 32'(FifoLevel), DEPTH);
        RxData = 8'h18; RxReady = 1'b1; seen = 1'b0;
        repeat (5) begin
            tick();
            if (RxEnable !== 1'b0) seen = 1'b1;
        end
        check("bp held no RxEnable", 32'(seen), 32'd0);
        check("bp level held", 32'(FifoLevel), DEPTH);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        check("bp level after pop", 32'(FifoLevel), DEPTH - 1);
        check("bp head after pop", 32'(OutData), 32'h11);
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            tick();
            if (RxEnable === 1'b1) seen = 1'b1;
        end
        check("bp ninth accepted", 32'(seen), 32'd1);
        tick();
        RxReady = 1'b0;
        check("bp level refilled", 32'(FifoLevel), DEPTH);
        OutReady = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("bp drain %0d", i), 32'(OutData), 32'(8'h10 + i));
            tick();
        end
        OutReady = 1'b0;
        check("bp drained", 32'(FifoLevel), 32'd0);

        // Write and pop on the same edge at level 1.
        sendByte(8'hC1, ok);
        check("wp first accept", 32'(ok), 32'd1);
        RxData = 8'hC2; RxReady = 1'b1; OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        check("wp RxEnable", 32'(RxEnable), 32'd1);
        check("wp level", 32'(FifoLevel), 32'd1);
        check("wp head", 32'(OutData), 32'hC2);
        tick();
        RxReady = 1'b0;
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        check("wp empty", 32'(FifoLevel), 32'd0);

        // Error counter saturation, then clear coincident with an error.
        for (int i = 0; i < 256; i++) begin
            RxError = 1'b1;
            tick();
            RxError = 1'b0;
            if (i == 0) check("err RxResetN low", 32'(RxResetN), 32'd0);
            if (i == 254) check("err count 255", 32'(ErrorCount), 32'd255);
            tick();
            tick();
        end
        check("err saturated", 32'(ErrorCount), 32'd255);
        check("err RxResetN back", 32'(RxResetN), 32'd1);
        RxError = 1'b1; ErrorClear = 1'b1;
        tick();
        RxError = 1'b0; ErrorClear = 1'b0;
        check("err clear with error", 32'(ErrorCount), 32'd1);
        tick();
        tick();

        // Asynchronous reset during RELEASE with three bytes stored.
        sendByte(8'hD1, ok);
        sendByte(8'hD2, ok);
        RxData = 8'hD3; RxReady = 1'b1;
        tick();
        check("rst pre RxEnable", 32'(RxEnable), 32'd1);
        check("rst pre level", 32'(FifoLevel), 32'd3);
        Reset = 1'b0;
        #1;
        check("rst RxEnable", 32'(RxEnable), 32'd0);
        check("rst RxResetN", 32'(RxResetN), 32'd0);
        check("rst OutValid", 32'(OutValid), 32'd0);
        check("rst FifoLevel", 32'(FifoLevel), 32'd0);
        check("rst ErrorCount", 32'(ErrorCount), 32'd0);
        RxReady = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        sendByte(8'h5A, ok);
        check("rst resume accept", 32'(ok), 32'd1);
        check("rst resume level", 32'(FifoLevel), 32'd1);
        check("rst resume data", 32'(OutData), 32'h5A);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;

        // Randomized traffic against a queue model of the FIFO.
        q.delete();
        lastPop    = 8'h5A;
        prevAccept = 1'b0;
        stage      = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (stage == 1) begin
                stage = 2;
            end else if (stage == 2) begin
                RxReady = 1'b0;
                stage   = 0;
            end
            if (stage == 0 && !RxReady && $urandom_range(0, 2) == 0) begin
                RxReady = 1'b1;
                RxData  = 8'($urandom);
            end
            if (cyc < 400) OutReady = ($urandom_range(0, 3) == 0);
            else           OutReady = ($urandom_range(0, 3) != 0);

            accept = RxReady && (q.size() < DEPTH) && !prevAccept;
            if (OutReady && q.size() > 0) lastPop = q.pop_front();
            if (accept) begin
                q.push_back(RxData);
                stage = 1;
            end
            prevAccept = accept;
            tick();
            check("rnd RxEnable", 32'(RxEnable), 32'(accept));
            check("rnd FifoLevel", 32'(FifoLevel), 32'(q.size()));
            check("rnd OutValid", 32'(OutValid), 32'(q.size() > 0));
            check("rnd OutData", 32'(OutData), (q.size() > 0) ? 32'(q[0]) : 32'(lastPop));
        end
        check("rnd ErrorCount", 32'(ErrorCount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
